// File: rtl/fetch_pkg.sv
// Shared constants and bundle types for the instruction-fetch stage.
// Queue entries pair a fetched word with the PC it was fetched from.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO used for both the instruction queue and the
// in-flight request PC tracker; DEPTH must be a power of two.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PINC = AW'(1);
  localparam logic [AW:0]   CINC = (AW+1)'(1);

  T              mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PINC;
      if (do_pop)  rd_q <= rd_q + PINC;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CINC;
        2'b01:   cnt_q <= cnt_q - CINC;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC generation, credit-limited imem requests,
// redirect squashing and a small queue toward decode. FETCH_PERF_EN adds counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_pcplus4,
  input  logic            dec_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  logic [XLEN-1:0] pc_q;
  logic            run_q;
  logic [AW:0]     drop_q;
  logic [AW:0]     iq_cnt;
  logic [AW:0]     pcq_cnt;
  logic            iq_full;
  logic            iq_empty;
  logic            pcq_full;
  logic            pcq_empty;
  fetch_entry_t    iq_din;
  fetch_entry_t    iq_head;
  logic [XLEN-1:0] pcq_head;
  logic [CW-1:0]   inuse;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            pop;

  // queued plus in-flight words never exceed the queue capacity
  assign inuse    = CW'(iq_cnt) + CW'(pcq_cnt);
  assign imem_req_valid = run_q && !redirect_valid && !pcq_full
                          && (inuse < CW'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_keep = imem_rsp_valid && (drop_q == '0);
  assign pop      = dec_valid && dec_ready;
  assign iq_din   = '{instr: imem_rsp_data, pc: pcq_head};

  assign dec_valid   = !iq_empty;
  assign dec_instr   = iq_empty ? NOP_INSTR : iq_head.instr;
  assign dec_pc      = iq_empty ? pc_q : iq_head.pc;
  assign dec_pcplus4 = dec_pc + XLEN'(4);

  fetch_queue #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_iq (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rsp_keep && !redirect_valid),
    .din     (iq_din),
    .pop     (pop),
    .dout    (iq_head),
    .flush   (redirect_valid),
    .full    (iq_full),
    .empty   (iq_empty),
    .count   (iq_cnt)
  );

  fetch_queue #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_pcq (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (req_fire),
    .din     (pc_q),
    .pop     (imem_rsp_valid),
    .dout    (pcq_head),
    .flush   (1'b0),
    .full    (pcq_full),
    .empty   (pcq_empty),
    .count   (pcq_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= RESET_PC;
      run_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (redirect_valid) begin
        pc_q   <= redirect_pc & ~XLEN'(3);
        // everything still in flight after this edge is wrong-path
        drop_q <= pcq_cnt - (AW+1)'(imem_rsp_valid);
      end else begin
        if (req_fire) pc_q <= pc_q + XLEN'(4);
        if (rsp_drop) drop_q <= drop_q - (AW+1)'(1);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(rsp_keep && iq_full));
  a_rsp_tracked: assert property (@(posedge clk) disable iff (!reset_n)
    !(imem_rsp_valid && pcq_empty));

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      if (rsp_keep)               perf_fetched <= perf_fetched + 32'd1;
      if (rsp_drop)               perf_dropped <= perf_dropped + 32'd1;
      if (dec_ready && !dec_valid) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a bench-side imem model and an expected
// delivery queue filled as requests are accepted and drained at decode pops.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready = 1'b1;
  logic            imem_rsp_valid = 1'b0;
  logic [XLEN-1:0] imem_rsp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            dec_valid;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_pcplus4;
  logic            dec_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_dropped;
  logic [31:0]     perf_stall;
`endif

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pcplus4    (dec_pcplus4),
    .dec_ready      (dec_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          doomed;
  } mem_ent_t;

  mem_ent_t     inflight[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  acc_log[$];
  logic [31:0]  exp_addr;
  logic         rsp_hold = 1'b0;
  int           checks = 0;
  int           errors = 0;
  int           n_fetched, n_dropped, n_stall, n_pop;
  bit           first_pop_seen;
  logic [31:0]  first_pop_pc;
  bit           last_pop, last_rsp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // One clock: drive memory response, observe handshakes, advance to posedge+1.
  task automatic cycle();
    mem_ent_t     r;
    fetch_entry_t e;
    if (inflight.size() > 0 && !rsp_hold) begin
      r = inflight.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(r.addr);
      if (r.doomed) n_dropped++;
      else n_fetched++;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    last_rsp = imem_rsp_valid;
    last_pop = dec_valid && dec_ready;
    if (dec_ready && !dec_valid) n_stall++;
    if (dec_valid && dec_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_delivery: got pc=%h instr=%h want none",
                 dec_pc, dec_instr);
      end else begin
        e = exp_q.pop_front();
        if (dec_instr !== e.instr || dec_pc !== e.pc ||
            dec_pcplus4 !== e.pc + 32'd4) begin
          errors++;
          $display("FAIL delivery: got %h/%h/%h want %h/%h/%h",
                   dec_instr, dec_pc, dec_pcplus4, e.instr, e.pc, e.pc + 32'd4);
        end
      end
      n_pop++;
      if (!first_pop_seen) begin
        first_pop_seen = 1'b1;
        first_pop_pc   = dec_pc;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      checks++;
      if (imem_req_addr !== exp_addr) begin
        errors++;
        $display("FAIL req_addr: got %h want %h", imem_req_addr, exp_addr);
      end
      acc_log.push_back(imem_req_addr);
      inflight.push_back('{addr: imem_req_addr, doomed: 1'b0});
      exp_q.push_back('{instr: mem_word(exp_addr), pc: exp_addr});
      exp_addr = exp_addr + 32'd4;
    end
    if (redirect_valid) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL req_in_redirect: got %b want 0", imem_req_valid);
      end
      exp_q.delete();
      foreach (inflight[i]) inflight[i].doomed = 1'b1;
      exp_addr = redirect_pc & ~32'd3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    rsp_hold       = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: got req=%b dec=%b want 0/0",
               imem_req_valid, dec_valid);
    end
    checks++;
    if (dec_instr !== NOP_INSTR || dec_pc !== RPC ||
        dec_pcplus4 !== RPC + 32'd4 || imem_req_addr !== RPC) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%h/%h want %h/%h/%h/%h",
               dec_instr, dec_pc, dec_pcplus4, imem_req_addr,
               NOP_INSTR, RPC, RPC + 32'd4, RPC);
    end
    inflight.delete();
    exp_q.delete();
    acc_log.delete();
    exp_addr  = RPC;
    n_fetched = 0;
    n_dropped = 0;
    n_stall   = 0;
    n_pop     = 0;
    first_pop_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    dec_ready = 1'b1;
    repeat (30) cycle();
    checks++;
    if (n_pop < 8) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d pops want >=8", n_pop);
    end
    for (int i = 0; i < 4; i++) begin
      want = 32'(i * 4);
      checks++;
      if (acc_log.size() <= i || acc_log[i] !== want) begin
        errors++;
        $display("FAIL b2b_addr%0d: got %h want %h", i,
                 (acc_log.size() > i) ? acc_log[i] : 32'hx, want);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    bit          have;
    have = 1'b0;
    dec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (dec_valid) begin
        if (!have) begin
          held = dec_instr;
          have = 1'b1;
        end else begin
          checks++;
          if (dec_instr !== held) begin
            errors++;
            $display("FAIL stall_stable: got %h want %h", dec_instr, held);
          end
        end
      end
    end
    checks++;
    if (imem_req_valid !== 1'b0 || dec_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_credit: got req=%b dec=%b want 0/1",
               imem_req_valid, dec_valid);
    end
    checks++;
    if (exp_q.size() != DEPTH) begin
      errors++;
      $display("FAIL stall_count: got %0d want %0d", exp_q.size(), DEPTH);
    end
    dec_ready = 1'b1;
    repeat (12) cycle();
  endtask

  task automatic test_redirect_outstanding();
    int n;
    dec_ready = 1'b1;
    rsp_hold  = 1'b1;
    n = 0;
    while (!(inflight.size() == 2 && !dec_valid) && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL redir_setup: got timeout want 2 outstanding");
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    cycle();
    redirect_valid = 1'b0;
    rsp_hold       = 1'b0;
    acc_log.delete();
    first_pop_seen = 1'b0;
    n = 0;
    while (!first_pop_seen && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (!first_pop_seen || first_pop_pc !== 32'h100) begin
      errors++;
      $display("FAIL redir_first_pc: got %h want 00000100", first_pop_pc);
    end
    checks++;
    if (acc_log.size() == 0 || acc_log[0] !== 32'h100) begin
      errors++;
      $display("FAIL redir_first_req: got %h want 00000100",
               (acc_log.size() > 0) ? acc_log[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_coincide();
    int n;
    dec_ready      = 1'b1;
    rsp_hold       = 1'b0;
    imem_req_ready = 1'b1;
    n = 0;
    while (!(inflight.size() > 0 && dec_valid) && n < 20) begin
      cycle();
      n++;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    cycle();
    redirect_valid = 1'b0;
    checks++;
    if (!(last_pop && last_rsp)) begin
      errors++;
      $display("FAIL coincide_setup: got pop=%b rsp=%b want 1/1",
               last_pop, last_rsp);
    end
    checks++;
    if (dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL coincide_flush: got dec_valid=%b want 0", dec_valid);
    end
    first_pop_seen = 1'b0;
    n = 0;
    while (!first_pop_seen && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (!first_pop_seen || first_pop_pc !== 32'h300) begin
      errors++;
      $display("FAIL coincide_first_pc: got %h want 00000300", first_pop_pc);
    end
  endtask

  task automatic test_align_wrap();
    int n;
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    cycle();
    redirect_valid = 1'b0;
    acc_log.delete();
    n = 0;
    while (acc_log.size() < 1 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (acc_log.size() < 1 || acc_log[0] !== 32'h200) begin
      errors++;
      $display("FAIL align_addr: got %h want 00000200",
               (acc_log.size() > 0) ? acc_log[0] : 32'hx);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    cycle();
    redirect_valid = 1'b0;
    acc_log.delete();
    n = 0;
    while (acc_log.size() < 2 && n < 30) begin
      cycle();
      n++;
    end
    checks++;
    if (acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFC ||
        acc_log[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000",
               (acc_log.size() > 0) ? acc_log[0] : 32'hx,
               (acc_log.size() > 1) ? acc_log[1] : 32'hx);
    end
    repeat (8) cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      imem_req_ready = ($urandom_range(3) != 0);
      dec_ready      = ($urandom_range(2) != 0);
      rsp_hold       = ($urandom_range(3) == 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = $urandom();
      cycle();
    end
    redirect_valid = 1'b0;
    rsp_hold       = 1'b0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    repeat (10) cycle();
  endtask

  task automatic test_mid_reset();
    int n;
    dec_ready = 1'b1;
    repeat (5) cycle();
    do_reset();
    dec_ready = 1'b1;
    n = 0;
    while (!first_pop_seen && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (!first_pop_seen || first_pop_pc !== RPC) begin
      errors++;
      $display("FAIL midreset_first_pc: got %h want %h", first_pop_pc, RPC);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    dec_ready = 1'b1;
    repeat (6) cycle();
    rsp_hold = 1'b1;
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    rsp_hold       = 1'b0;
    repeat (8) cycle();
    checks++;
    if (perf_fetched !== 32'(n_fetched) || perf_dropped !== 32'(n_dropped) ||
        perf_stall !== 32'(n_stall)) begin
      errors++;
      $display("FAIL perf: got %0d/%0d/%0d want %0d/%0d/%0d",
               perf_fetched, perf_dropped, perf_stall,
               n_fetched, n_dropped, n_stall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect_outstanding();
    test_redirect_coincide();
    test_align_wrap();
    test_random();
    test_mid_reset();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
